// File: rtl/sjr_bench_pkg.sv
// Shared definitions for the Synthesijer method launcher.
//   state_e         : launcher FSM states
//   DEFAULT_TIMEOUT : default per-run cycle limit
package sjr_bench_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StReq      = 3'd1,
        StWaitBusy = 3'd2,
        StRun      = 3'd3,
        StCheck    = 3'd4,
        StDone     = 3'd5
    } state_e;

    localparam int unsigned DEFAULT_TIMEOUT = 1000000;

endpackage

// File: rtl/sjr_sat_counter.sv
// Saturating accumulator: clears, loads a value, or adds a value without wrapping.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_clr          : clear to zero (highest priority after reset)
//   i_load         : load i_value
//   i_inc          : add i_value, saturating at all-ones
//   i_value        : load / increment operand
//   o_count        : current value
module sjr_sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic             i_inc,
    input  logic [WIDTH-1:0] i_value,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH:0]   w_sum;

    // One extra bit catches the carry that would otherwise wrap.
    assign w_sum = {1'b0, r_count} + {1'b0, i_value};

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_inc) begin
            r_count <= w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/sjr_method_launcher.sv
// Run controller placed upstream of a Synthesijer method module. Issues one run_req pulse
// per run, follows run_busy, measures per-run and campaign cycle counts, checks the finish
// flag and aborts a run that exceeds TIMEOUT cycles (0 disables the limit).
//   i_clk, i_reset  : clock, synchronous active-high reset
//   i_start         : begin a campaign (accepted only when idle or done)
//   i_runs          : number of runs, sampled on accepted start (0 means 1)
//   o_run_req       : run request pulse to the method module
//   i_run_busy      : busy from the method module
//   i_finish_flag   : finish flag from the method module
//   o_active        : campaign in progress
//   o_done, o_pass  : campaign finished / every run finished cleanly
//   o_timeout       : a run hit the cycle limit (sticky until next start)
//   o_run_count     : completed runs in this campaign
//   o_last_cycles   : cycles of the most recent run, request through busy-fall
//   o_total_cycles  : saturating sum of run cycles over the campaign
module sjr_method_launcher
    import sjr_bench_pkg::*;
#(
    parameter int unsigned CYCLE_W = 32,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
    parameter int unsigned RUNS_W  = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [RUNS_W-1:0]  i_runs,
    output logic               o_run_req,
    input  logic               i_run_busy,
    input  logic               i_finish_flag,
    output logic               o_active,
    output logic               o_done,
    output logic               o_pass,
    output logic               o_timeout,
    output logic [RUNS_W-1:0]  o_run_count,
    output logic [CYCLE_W-1:0] o_last_cycles,
    output logic [CYCLE_W-1:0] o_total_cycles
);

    state_e              r_state;
    state_e              w_state_d;
    logic                r_finish_prev;
    logic [RUNS_W-1:0]   r_runs_lat;
    logic                r_run_req;
    logic                r_active;
    logic                r_done;
    logic                r_pass;
    logic                r_timeout;
    logic [RUNS_W-1:0]   r_run_count;
    logic [CYCLE_W-1:0]  r_last_cycles;

    logic [CYCLE_W-1:0]  w_run_cycles;
    logic                w_start_ok;
    logic                w_counting;
    logic                w_timeout_hit;
    logic                w_more_runs;

    assign w_start_ok    = i_start && ((r_state == StIdle) || (r_state == StDone));
    assign w_counting    = (r_state == StWaitBusy) || (r_state == StRun);
    assign w_timeout_hit = (TIMEOUT != 0) && w_counting
                           && (w_run_cycles == CYCLE_W'(TIMEOUT));
    // Widened by one bit so runs == all-ones cannot wrap the comparison.
    assign w_more_runs   = ((RUNS_W+1)'(r_run_count) + (RUNS_W+1)'(1))
                           < (RUNS_W+1)'(r_runs_lat);

    // Per-run counter: loaded to 1 in REQ, +1 every WAIT_BUSY/RUN cycle.
    sjr_sat_counter #(
        .WIDTH (CYCLE_W)
    ) u_run_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (1'b0),
        .i_load  (w_state_d == StReq),
        .i_inc   (w_counting),
        .i_value (CYCLE_W'(1)),
        .o_count (w_run_cycles)
    );

    // Campaign total: cleared on accepted start, accumulates in CHECK.
    sjr_sat_counter #(
        .WIDTH (CYCLE_W)
    ) u_total_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_start_ok),
        .i_load  (1'b0),
        .i_inc   (r_state == StCheck),
        .i_value (w_run_cycles),
        .o_count (o_total_cycles)
    );

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle, StDone: if (w_start_ok) w_state_d = StReq;
            StReq:          w_state_d = StWaitBusy;
            StWaitBusy: begin
                if (w_timeout_hit)                          w_state_d = StDone;
                else if (i_run_busy)                        w_state_d = StRun;
                // Run finished before busy was ever seen.
                else if (i_finish_flag && !r_finish_prev)   w_state_d = StCheck;
            end
            StRun: begin
                if (w_timeout_hit)    w_state_d = StDone;
                else if (!i_run_busy) w_state_d = StCheck;
            end
            StCheck:        w_state_d = w_more_runs ? StReq : StDone;
            default:        w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= StIdle;
            r_finish_prev <= 1'b0;
            r_runs_lat    <= '0;
            r_run_req     <= 1'b0;
            r_active      <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_timeout     <= 1'b0;
            r_run_count   <= '0;
            r_last_cycles <= '0;
        end else begin
            r_state       <= w_state_d;
            r_finish_prev <= i_finish_flag;
            r_run_req     <= (w_state_d == StReq);
            r_active      <= (w_state_d != StIdle) && (w_state_d != StDone);
            r_done        <= (w_state_d == StDone);
            if (w_start_ok) begin
                r_run_count <= '0;
                r_timeout   <= 1'b0;
                r_pass      <= 1'b1;
                r_runs_lat  <= (i_runs == '0) ? RUNS_W'(1) : i_runs;
            end
            if (w_timeout_hit) begin
                r_timeout     <= 1'b1;
                r_pass        <= 1'b0;
                r_last_cycles <= CYCLE_W'(TIMEOUT);
            end
            if (r_state == StCheck) begin
                r_last_cycles <= w_run_cycles;
                r_run_count   <= r_run_count + RUNS_W'(1);
                if (!i_finish_flag) r_pass <= 1'b0;
            end
        end
    end

    assign o_run_req     = r_run_req;
    assign o_active      = r_active;
    assign o_done        = r_done;
    assign o_pass        = r_pass;
    assign o_timeout     = r_timeout;
    assign o_run_count   = r_run_count;
    assign o_last_cycles = r_last_cycles;

endmodule

// File: tb/tb_sjr_method_launcher.sv
// Directed self-checking bench for sjr_method_launcher with a small behavioural model of
// the method module: busy rises m_delay cycles after run_req and stays high m_len cycles;
// finish_flag is high after busy falls unless the run index equals fail_idx.
module tb_sjr_method_launcher;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  runs = 8'd0;
    logic        run_req;
    logic        run_busy;
    logic        finish_flag;
    logic        active;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [7:0]  run_count;
    logic [31:0] last_cycles;
    logic [31:0] total_cycles;

    int errors = 0;
    int checks = 0;

    // Method-module model state.
    int m_delay  = 2;
    int m_len    = 10;
    int fail_idx = -1;
    int m_cnt    = 0;
    int m_run    = 0;
    int req_total = 0;

    always #5 clk = ~clk;

    sjr_method_launcher #(
        .CYCLE_W (32),
        .TIMEOUT (50),
        .RUNS_W  (8)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_start        (start),
        .i_runs         (runs),
        .o_run_req      (run_req),
        .i_run_busy     (run_busy),
        .i_finish_flag  (finish_flag),
        .o_active       (active),
        .o_done         (done),
        .o_pass         (pass),
        .o_timeout      (timeout),
        .o_run_count    (run_count),
        .o_last_cycles  (last_cycles),
        .o_total_cycles (total_cycles)
    );

    always @(posedge clk) begin
        if (reset) begin
            m_cnt <= 0;
        end else if (run_req) begin
            m_cnt     <= 1;
            m_run     <= req_total;
            req_total <= req_total + 1;
        end else if (m_cnt != 0 && m_cnt <= m_delay + m_len) begin
            m_cnt <= m_cnt + 1;
        end
    end

    assign run_busy    = (m_cnt != 0) && (m_cnt >= m_delay) && (m_cnt < m_delay + m_len);
    assign finish_flag = (m_cnt != 0) && (m_cnt >= m_delay + m_len) && (m_run != fail_idx);

    task automatic pulse_start(input logic [7:0] r);
        runs  = r;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output int n);
        n = 0;
        while (done !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (run_req !== 1'b0) begin errors++; $display("FAIL reset_run_req: got %b want 0", run_req); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", active); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass: got %b want 0", pass); end
        checks++; if (run_count !== 8'd0) begin errors++; $display("FAIL reset_run_count: got %0d want 0", run_count); end
        checks++; if (total_cycles !== 32'd0) begin errors++; $display("FAIL reset_total: got %0d want 0", total_cycles); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single;
        int n;
        int base;
        m_delay = 2; m_len = 10; fail_idx = -1;
        base = req_total;
        pulse_start(8'd1);
        checks++; if (run_req !== 1'b1) begin errors++; $display("FAIL single_req_latency: got %b want 1", run_req); end
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL single_active: got %b want 1", active); end
        wait_done(100, n);
        // REQ at t0, busy t2..t11, fall t12, CHECK t13, DONE visible t14.
        checks++; if (n !== 14) begin errors++; $display("FAIL single_done_latency: got %0d want 14", n); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL single_pass: got %b want 1", pass); end
        checks++; if (run_count !== 8'd1) begin errors++; $display("FAIL single_run_count: got %0d want 1", run_count); end
        checks++; if (last_cycles !== 32'd13) begin errors++; $display("FAIL single_last: got %0d want 13", last_cycles); end
        checks++; if (total_cycles !== 32'd13) begin errors++; $display("FAIL single_total: got %0d want 13", total_cycles); end
        checks++; if (req_total - base !== 1) begin errors++; $display("FAIL single_req_pulses: got %0d want 1", req_total - base); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL single_inactive: got %b want 0", active); end
    endtask

    task automatic test_multi_run;
        int n;
        int base;
        m_delay = 2; m_len = 5; fail_idx = -1;
        base = req_total;
        pulse_start(8'd3);
        wait_done(200, n);
        repeat (5) @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL multi_done: got %b want 1", done); end
        checks++; if (req_total - base !== 3) begin errors++; $display("FAIL multi_req_pulses: got %0d want 3", req_total - base); end
        checks++; if (run_count !== 8'd3) begin errors++; $display("FAIL multi_run_count: got %0d want 3", run_count); end
        checks++; if (last_cycles !== 32'd8) begin errors++; $display("FAIL multi_last: got %0d want 8", last_cycles); end
        checks++; if (total_cycles !== 32'd24) begin errors++; $display("FAIL multi_total: got %0d want 24", total_cycles); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL multi_pass: got %b want 1", pass); end
    endtask

    task automatic test_timeout;
        int n;
        int base;
        m_delay = 2; m_len = 1000; fail_idx = -1;
        base = req_total;
        pulse_start(8'd1);
        wait_done(200, n);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL timeout_done: got %b want 1", done); end
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b want 1", timeout); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL timeout_pass: got %b want 0", pass); end
        checks++; if (last_cycles !== 32'd50) begin errors++; $display("FAIL timeout_last: got %0d want 50", last_cycles); end
        checks++; if (run_count !== 8'd0) begin errors++; $display("FAIL timeout_run_count: got %0d want 0", run_count); end
        checks++; if (total_cycles !== 32'd0) begin errors++; $display("FAIL timeout_total: got %0d want 0", total_cycles); end
        repeat (10) @(negedge clk);
        checks++; if (req_total - base !== 1) begin errors++; $display("FAIL timeout_no_rerun: got %0d want 1", req_total - base); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL timeout_done_held: got %b want 1", done); end
        m_len = 0;
        @(negedge clk);
    endtask

    task automatic test_finish_fail;
        int n;
        m_delay = 2; m_len = 5;
        fail_idx = req_total;
        pulse_start(8'd2);
        wait_done(200, n);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ffail_done: got %b want 1", done); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL ffail_pass: got %b want 0", pass); end
        checks++; if (run_count !== 8'd2) begin errors++; $display("FAIL ffail_run_count: got %0d want 2", run_count); end
        checks++; if (total_cycles !== 32'd16) begin errors++; $display("FAIL ffail_total: got %0d want 16", total_cycles); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL ffail_timeout_cleared: got %b want 0", timeout); end
        fail_idx = -1;
    endtask

    task automatic test_reset_midrun;
        int n;
        m_delay = 2; m_len = 10; fail_idx = -1;
        pulse_start(8'd1);
        n = 0;
        while (run_busy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        // Busy first seen in WAIT_BUSY (t2); RUN cycle 4 is t6.
        repeat (4) @(negedge clk);
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL midrun_active: got %b want 1", active); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL midrun_rst_active: got %b want 0", active); end
        checks++; if (last_cycles !== 32'd0) begin errors++; $display("FAIL midrun_rst_last: got %0d want 0", last_cycles); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL midrun_rst_pass: got %b want 0", pass); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrun_rst_done: got %b want 0", done); end
        @(negedge clk);
        pulse_start(8'd1);
        wait_done(100, n);
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL midrun_rerun_pass: got %b want 1", pass); end
        checks++; if (last_cycles !== 32'd13) begin errors++; $display("FAIL midrun_rerun_last: got %0d want 13", last_cycles); end
    endtask

    task automatic test_start_while_active;
        int n;
        int base;
        m_delay = 2; m_len = 10; fail_idx = -1;
        base = req_total;
        pulse_start(8'd0);
        repeat (4) @(negedge clk);
        pulse_start(8'd3);
        wait_done(100, n);
        repeat (5) @(negedge clk);
        checks++; if (req_total - base !== 1) begin errors++; $display("FAIL busystart_req_pulses: got %0d want 1", req_total - base); end
        checks++; if (run_count !== 8'd1) begin errors++; $display("FAIL busystart_run_count: got %0d want 1", run_count); end
        checks++; if (last_cycles !== 32'd13) begin errors++; $display("FAIL busystart_last: got %0d want 13", last_cycles); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL busystart_pass: got %b want 1", pass); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi_run();
        test_timeout();
        test_finish_fail();
        test_reset_midrun();
        test_start_while_active();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
